gcd_ctrl: RTL and testbench
===========================

Name: gcd_ctrl

Overview:
Control unit for the subtractive GCD datapath. It sequences operand load, the compare/subtract iterations and result output enable. It drives the datapath select and load strobes from the datapath comparator flags, and gives the system a four-phase START/DONE handshake. An iteration watchdog flags non-terminating operand pairs, such as one zero operand.

Parameters:
MAX_ITER, 255, subtraction iterations allowed before ERROR (255 covers every nonzero 8-bit pair).
CNT_W, 8, width of the iteration counter and ITER output; must satisfy 2^CNT_W > MAX_ITER.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
START  in  1  level request; four-phase handshake with DONE/ERROR
XEQY  in  1  datapath comparator: X == Y (combinational from registers)
XGTY  in  1  datapath comparator: X > Y
IN_X  out  1  X mux select: 1 = external operand, 0 = subtractor
IN_Y  out  1  Y mux select: 1 = external operand, 0 = subtractor
LOAD_X  out  1  X register load enable
LOAD_Y  out  1  Y register load enable
XY  out  1  subtractor order: 1 = X-Y, 0 = Y-X
OUT_DP  out  1  datapath output buffer enable (result = X)
BUSY  out  1  high in LOAD and CALC
DONE  out  1  result valid
ERROR  out  1  watchdog expired
ITER  out  CNT_W  subtraction count of the current/last computation

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, iteration counter=0. All outputs 0, including ITER.
- States: IDLE, LOAD, CALC, FIN, ERR. State and counter are registered. Outputs are decoded from state. In CALC, outputs also depend combinationally on XEQY/XGTY.
- IDLE: all strobes 0. START=1 at a clock edge -> LOAD and counter cleared to 0.
- LOAD: IN_X=IN_Y=LOAD_X=LOAD_Y=1 and BUSY=1 for exactly one cycle. Next state is CALC.
- CALC: BUSY=1; checks are applied in this order:
  - XEQY=1: no strobes; next state FIN. XEQY takes priority over XGTY and over the watchdog.
  - else if counter == MAX_ITER: no strobes; next state ERR.
  - else if XGTY=1: XY=1, LOAD_X=1, IN_X=0 (X <= X-Y); counter+1.
  - else: XY=0, LOAD_Y=1, IN_Y=0 (Y <= Y-X); counter+1.
  - LOAD_X and LOAD_Y are never both 1 in CALC.
- FIN: DONE=1, OUT_DP=1; all other strobes 0. Stays while START=1; START=0 -> IDLE.
- ERR: ERROR=1, OUT_DP=0. Stays while START=1; START=0 -> IDLE.
- ITER = counter. It holds its value through FIN/ERR and IDLE, and clears only when a new START is accepted.
- START falling during LOAD/CALC is ignored; the computation completes. START held high after FIN/ERR never auto-restarts.
- Latency: with START sampled at edge e0 and N subtractions, FIN or ERR is entered at edge e0+N+2.
- Boundary cases:
  - (0,0): XEQY on first CALC -> FIN, ITER=0, result 0.
  - (0,k) or (k,0) with k>0: never equal -> ERR after MAX_ITER subtractions.
  - Reset mid-CALC: immediate IDLE with all outputs 0.
- Counter saturates by construction: it cannot pass MAX_ITER.

Decomposition:
- Package gcd_pkg holds:
  - state enum (IDLE, LOAD, CALC, FIN, ERR) with a 3-bit encoding;
  - default MAX_ITER constant;
  - DATA_W=8 constant, shared with the datapath.
- Sub-module iter_counter: CNT_W-bit counter with clear, increment and a terminal flag (count == MAX_ITER).
- The FSM with output decode stays in gcd_ctrl.
- A top gcd_top wires gcd_ctrl to the datapath; the bench uses it for end-to-end checks.

Test Plan:
1. Reset: hold reset=0 with START=1 and random XEQY/XGTY -> all outputs 0 and ITER=0; release reset -> LOAD on the first edge with START=1.
2. gcd_top with operands (12,8), START=1:
   - CALC strobes are LOAD_X/XY=1, then LOAD_Y/XY=0.
   - DONE=1 at edge e0+4; OUTPUT=4, OUT_DP=1, ITER=2.
   - START=0 -> IDLE next edge; DONE=0 and OUT_DP=0.
3. Operands (255,1) -> DONE with OUTPUT=1 and ITER=254 at e0+256; no ERROR.
4. Operands (0,9) with MAX_ITER=255 -> ERROR=1 at e0+257, ITER=255, OUT_DP=0. (0,0) -> DONE, OUTPUT=0, ITER=0.
5. Handshake:
   - START dropped mid-CALC for (48,18): computation completes with OUTPUT=6, then IDLE.
   - START held high through FIN for 10 cycles: stays in FIN, no restart.
   - Re-raising START restarts the computation and clears ITER.
6. Assert reset=0 asynchronously between edges during CALC -> outputs go 0 without waiting for a clock. After release, a new START for (21,14) -> OUTPUT=7.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared constants and state encoding for the subtractive GCD controller and datapath.
package gcd_pkg;

  localparam int DATA_W       = 8;
  localparam int MAX_ITER_DEF = 255;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    FIN  = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/gcd_if.sv
// Controller <-> datapath/system signal bundle: handshake, comparator flags and strobes.
interface gcd_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic             XEQY;
  logic             XGTY;
  logic             IN_X;
  logic             IN_Y;
  logic             LOAD_X;
  logic             LOAD_Y;
  logic             XY;
  logic             OUT_DP;
  logic             BUSY;
  logic             DONE;
  logic             ERROR;
  logic [CNT_W-1:0] ITER;

  modport master (
    input  START, XEQY, XGTY,
    output IN_X, IN_Y, LOAD_X, LOAD_Y, XY, OUT_DP, BUSY, DONE, ERROR, ITER
  );

  modport slave (
    output START, XEQY, XGTY,
    input  IN_X, IN_Y, LOAD_X, LOAD_Y, XY, OUT_DP, BUSY, DONE, ERROR, ITER
  );
endinterface

// File: rtl/gcd_ctrl_iter_counter.sv
// Iteration counter for the GCD watchdog: clear, increment, and a terminal flag at MAX_ITER.
module iter_counter #(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(MAX_ITER);

  assign term = (count == TERM_VAL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !term)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/gcd_top.sv
// GCD system: controller plus the X/Y register, subtractor and comparator datapath.
module gcd_top
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              START,
  input  logic [DATA_W-1:0] X_IN,
  input  logic [DATA_W-1:0] Y_IN,
  output logic [DATA_W-1:0] OUTPUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [CNT_W-1:0]  ITER
);

  gcd_if #(.CNT_W(CNT_W)) bus ();

  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] diff;

  gcd_ctrl #(
    .MAX_ITER (MAX_ITER),
    .CNT_W    (CNT_W)
  ) u_gcd_ctrl (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.START = START;
  assign bus.XEQY  = (x_q == y_q);
  assign bus.XGTY  = (x_q > y_q);
  assign diff      = bus.XY ? (x_q - y_q) : (y_q - x_q);

  // Datapath registers carry no control meaning, so they are left without reset.
  always_ff @(posedge clk) begin
    if (bus.LOAD_X) x_q <= bus.IN_X ? X_IN : diff;
    if (bus.LOAD_Y) y_q <= bus.IN_Y ? Y_IN : diff;
  end

  assign OUTPUT = bus.OUT_DP ? x_q : '0;
  assign BUSY   = bus.BUSY;
  assign DONE   = bus.DONE;
  assign ERROR  = bus.ERROR;
  assign ITER   = bus.ITER;

endmodule

// File: rtl/gcd_ctrl.sv
// Subtractive GCD control unit: START/DONE handshake, compare/subtract sequencing, iteration watchdog.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  gcd_if.master bus
);

  state_t state;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_term;

  assign cnt_clr = (state == IDLE) && bus.START;
  assign cnt_inc = (state == CALC) && !bus.XEQY && !cnt_term;

  iter_counter #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (bus.ITER),
    .term  (cnt_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.START) state <= LOAD;
        LOAD:    state <= CALC;
        // Equality wins over the watchdog so a pair finishing on the last allowed step still succeeds.
        CALC:    if (bus.XEQY) state <= FIN;
                 else if (cnt_term) state <= ERR;
        FIN,
        ERR:     if (!bus.START) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    bus.IN_X   = 1'b0;
    bus.IN_Y   = 1'b0;
    bus.LOAD_X = 1'b0;
    bus.LOAD_Y = 1'b0;
    bus.XY     = 1'b0;
    bus.OUT_DP = 1'b0;
    bus.BUSY   = 1'b0;
    bus.DONE   = 1'b0;
    bus.ERROR  = 1'b0;
    case (state)
      LOAD: begin
        bus.IN_X   = 1'b1;
        bus.IN_Y   = 1'b1;
        bus.LOAD_X = 1'b1;
        bus.LOAD_Y = 1'b1;
        bus.BUSY   = 1'b1;
      end
      CALC: begin
        bus.BUSY = 1'b1;
        if (!bus.XEQY && !cnt_term) begin
          if (bus.XGTY) begin
            bus.XY     = 1'b1;
            bus.LOAD_X = 1'b1;
          end else begin
            bus.LOAD_Y = 1'b1;
          end
        end
      end
      FIN: begin
        bus.DONE   = 1'b1;
        bus.OUT_DP = 1'b1;
      end
      ERR:     bus.ERROR = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl: directed operand pairs through a bench-side GCD datapath.
module tb_gcd_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gcd_if #(.CNT_W(8)) bus ();

  gcd_ctrl #(
    .MAX_ITER (255),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bench-side datapath: X/Y registers, subtractor, comparator.
  logic [7:0] ext_x = 8'd0, ext_y = 8'd0;
  logic [7:0] x_q = 8'd0, y_q = 8'd0;
  logic       rnd_mode = 1'b1;
  logic       rnd_eq = 1'b0, rnd_gt = 1'b0;

  assign bus.XEQY = rnd_mode ? rnd_eq : (x_q == y_q);
  assign bus.XGTY = rnd_mode ? rnd_gt : (x_q > y_q);

  always @(posedge clk) begin
    if (bus.LOAD_X) x_q <= bus.IN_X ? ext_x : (bus.XY ? x_q - y_q : y_q - x_q);
    if (bus.LOAD_Y) y_q <= bus.IN_Y ? ext_y : (bus.XY ? x_q - y_q : y_q - x_q);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
  endtask

  typedef struct {
    logic [7:0] res;
    logic [7:0] iter;
    bit         err;
    int         e0;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [8:0] strobes();
    return {bus.IN_X, bus.IN_Y, bus.LOAD_X, bus.LOAD_Y, bus.XY,
            bus.OUT_DP, bus.BUSY, bus.DONE, bus.ERROR};
  endfunction

  // Monitor: pops one expectation each time DONE or ERROR rises.
  logic fin_prev = 1'b0;
  always @(negedge clk) begin
    logic fin_now;
    exp_t e;
    fin_now = bus.DONE | bus.ERROR;
    if (fin_now && !fin_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_flag", 32'(bus.DONE), 32'(!e.err));
        check("error_flag", 32'(bus.ERROR), 32'(e.err));
        check("out_dp", 32'(bus.OUT_DP), 32'(!e.err));
        check("iter", 32'(bus.ITER), 32'(e.iter));
        check("latency", 32'(cyc - e.e0), 32'(e.iter) + 32'd2);
        if (!e.err) check("result", 32'(x_q), 32'(e.res));
      end
    end
    fin_prev = fin_now;
  end

  task automatic wait_finish(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bus.DONE | bus.ERROR;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic [7:0] it, input bit err,
                        input bit drop_mid, input int hold);
    exp_t e;
    @(negedge clk);
    ext_x = a;
    ext_y = b;
    bus.START = 1'b1;
    e.res = res; e.iter = it; e.err = err; e.e0 = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    check({name, "_load_strobes"}, 32'(strobes()), 32'b111100100);
    check({name, "_load_iter"}, 32'(bus.ITER), 32'd0);
    if (drop_mid) begin
      @(negedge clk);
      bus.START = 1'b0;
    end
    wait_finish(name);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_fin"}, 32'({bus.DONE, bus.ERROR, bus.BUSY}), {29'd0, !err, err, 1'b0});
    end
    bus.START = 1'b0;
    @(negedge clk);
    if (!drop_mid) @(negedge clk);
    check({name, "_idle_strobes"}, 32'(strobes()), 32'd0);
    check({name, "_idle_iter"}, 32'(bus.ITER), 32'(it));
  endtask

  initial begin
    bus.START = 1'b1;
    ext_x = 8'd12;
    ext_y = 8'd8;

    // Reset held with START high and random comparator flags.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rnd_eq = 1'($urandom_range(0, 1));
      rnd_gt = 1'($urandom_range(0, 1));
      #1;
      check("reset_strobes", 32'(strobes()), 32'd0);
      check("reset_iter", 32'(bus.ITER), 32'd0);
    end

    // Release with START already high: (12,8) with per-cycle strobe checks.
    begin
      exp_t e;
      @(negedge clk);
      rnd_mode = 1'b0;
      reset = 1'b1;
      e.res = 8'd4; e.iter = 8'd2; e.err = 1'b0; e.e0 = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check("first_load", 32'(strobes()), 32'b111100100);
    @(negedge clk);
    check("calc_x_minus_y", 32'(strobes()), 32'b001010100);
    @(negedge clk);
    check("calc_y_minus_x", 32'(strobes()), 32'b000100100);
    @(negedge clk);
    check("calc_equal", 32'(strobes()), 32'b000000100);
    @(negedge clk);
    check("fin_strobes", 32'(strobes()), 32'b000001010);
    bus.START = 1'b0;
    @(negedge clk);
    check("fin_to_idle", 32'(strobes()), 32'd0);
    check("iter_kept", 32'(bus.ITER), 32'd2);

    run_op("gcd_255_1", 8'd255, 8'd1, 8'd1, 8'd254, 1'b0, 1'b0, 0);
    run_op("gcd_0_9",   8'd0,   8'd9, 8'd0, 8'd255, 1'b1, 1'b0, 0);
    run_op("gcd_9_0",   8'd9,   8'd0, 8'd0, 8'd255, 1'b1, 1'b0, 0);
    run_op("gcd_0_0",   8'd0,   8'd0, 8'd0, 8'd0,   1'b0, 1'b0, 0);
    run_op("gcd_48_18", 8'd48, 8'd18, 8'd6, 8'd4,   1'b0, 1'b1, 0);
    run_op("hold_12_8", 8'd12,  8'd8, 8'd4, 8'd2,   1'b0, 1'b0, 10);
    run_op("gcd_7_7",   8'd7,   8'd7, 8'd7, 8'd0,   1'b0, 1'b0, 0);

    // Asynchronous reset between edges during a long CALC.
    @(negedge clk);
    ext_x = 8'd255;
    ext_y = 8'd1;
    bus.START = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_reset_busy", 32'(bus.BUSY), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_strobes", 32'(strobes()), 32'd0);
    check("async_reset_iter", 32'(bus.ITER), 32'd0);
    bus.START = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op("gcd_21_14", 8'd21, 8'd14, 8'd7, 8'd2, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
